exe_alu_unit: RTL and testbench

EXE_ALU_UNIT -- requirements
Module: exe_alu_unit

---
 rtl/exe_alu_unit.sv | 104 ++++++++++
 tb/tb_exe_alu_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/exe_alu_unit.sv
// Execute-stage ALU: second-operand shifter, ALU with NZCV flags
// and branch target adder, all outputs registered (1-cycle latency).
module exe_alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  EXE_CMD,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] PC,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic [11:0] Shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  SR,
    output logic [31:0] ALU_result,
    output logic [31:0] Br_addr,
    output logic [3:0]  status
);

    logic [31:0] val2;
    logic [31:0] imm32;
    logic [4:0]  shamt;
    logic [4:0]  rot;
    logic [31:0] res;
    logic [32:0] sum;
    logic        c_out;
    logic        v_out;
    logic        flags_ok;
    logic        cin;
    logic        unused_bit4;

    assign unused_bit4 = Shift_operand[4];
    assign cin   = SR[1];
    assign shamt = Shift_operand[11:7];
    assign rot   = {Shift_operand[11:8], 1'b0};
    assign imm32 = {24'b0, Shift_operand[7:0]};

    // Rotations use the two-sided shift; a right shift of 0 leaves
    // the left term shifted by 32, which is 0, so amount 0 is a pass.
    always_comb begin
        val2 = 32'b0;
        if (MEM_R_EN || MEM_W_EN) begin
            val2 = {20'b0, Shift_operand};
        end else if (imm) begin
            val2 = (imm32 >> rot) | (imm32 << (6'd32 - {1'b0, rot}));
        end else begin
            case (Shift_operand[6:5])
                2'b00:   val2 = Val_Rm << shamt;
                2'b01:   val2 = Val_Rm >> shamt;
                2'b10:   val2 = $signed(Val_Rm) >>> shamt;
                default: val2 = (Val_Rm >> shamt)
                              | (Val_Rm << (6'd32 - {1'b0, shamt}));
            endcase
        end
    end

    always_comb begin
        sum      = 33'b0;
        res      = 32'b0;
        c_out    = 1'b0;
        v_out    = 1'b0;
        flags_ok = 1'b1;
        case (EXE_CMD)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010, 4'b0011: begin
                sum = {1'b0, Val_Rn} + {1'b0, val2}
                    + {32'b0, (EXE_CMD[0] & cin)};
                res   = sum[31:0];
                c_out = sum[32];
                v_out = (Val_Rn[31] == val2[31])
                      && (res[31] != Val_Rn[31]);
            end
            4'b0100, 4'b0101: begin
                sum = {1'b0, Val_Rn} + {1'b0, ~val2}
                    + {32'b0, (EXE_CMD[0] ? cin : 1'b1)};
                res   = sum[31:0];
                c_out = sum[32];
                v_out = (Val_Rn[31] != val2[31])
                      && (res[31] != Val_Rn[31]);
            end
            4'b0110: res = Val_Rn & val2;
            4'b0111: res = Val_Rn | val2;
            4'b1000: res = Val_Rn ^ val2;
            default: flags_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALU_result <= 32'b0;
            Br_addr    <= 32'b0;
            status     <= 4'b0;
        end else begin
            ALU_result <= res;
            Br_addr    <= PC + {{8{Signed_imm_24[23]}}, Signed_imm_24};
            status     <= flags_ok
                        ? {res[31], (res == 32'b0), c_out, v_out}
                        : 4'b0;
        end
    end

endmodule

// File: tb/tb_exe_alu_unit.sv
// Directed bench for exe_alu_unit with hand-computed expectations.
module tb_exe_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  EXE_CMD;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] PC;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  SR;
    logic [31:0] ALU_result;
    logic [31:0] Br_addr;
    logic [3:0]  status;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010,
                           ADC = 4'b0011, SUB = 4'b0100, SBC = 4'b0101,
                           AND = 4'b0110, ORR = 4'b0111, EOR = 4'b1000;

    exe_alu_unit dut (
        .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .PC(PC),
        .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
        .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
        .SR(SR), .ALU_result(ALU_result), .Br_addr(Br_addr),
        .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic op(input logic [3:0] cmd, input logic [31:0] rn,
                      input logic [31:0] rm, input logic im,
                      input logic [11:0] sh, input logic [3:0] sr);
        EXE_CMD = cmd; Val_Rn = rn; Val_Rm = rm;
        imm = im; Shift_operand = sh; SR = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        EXE_CMD = ADD; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        PC = 32'h100; Val_Rn = 32'h5; Val_Rm = 32'h7; imm = 1'b0;
        Shift_operand = 12'h0; Signed_imm_24 = 24'h4; SR = 4'b0;
        #2;
        chk("rst_res", ALU_result, 32'h0);
        chk("rst_br", Br_addr, 32'h0);
        chk("rst_st", {28'b0, status}, 32'h0);
        @(posedge clk); #1;
        chk("rst_hold", ALU_result, 32'h0);
        #3 rst = 1'b1;

        op(ADD, 32'h7FFFFFFF, 32'h0, 1'b1, 12'h001, 4'b0);
        chk("add_ovf", ALU_result, 32'h80000000);
        chk("add_ovf_st", {28'b0, status}, 32'h9);
        op(ADD, 32'hFFFFFFFF, 32'h0, 1'b1, 12'h001, 4'b0);
        chk("add_carry", ALU_result, 32'h0);
        chk("add_carry_st", {28'b0, status}, 32'h6);
        op(MOV, 32'h0, 32'h0, 1'b1, 12'h4FF, 4'b0);
        chk("mov_rot", ALU_result, 32'hFF000000);
        chk("mov_rot_st", {28'b0, status}, 32'h8);
        op(MOV, 32'h0, 32'h80000000, 1'b0, 12'h240, 4'b0);
        chk("mov_asr4", ALU_result, 32'hF8000000);
        op(MOV, 32'h0, 32'h00000001, 1'b0, 12'hF80, 4'b0);
        chk("lsl31", ALU_result, 32'h80000000);
        op(MOV, 32'h0, 32'h80000000, 1'b0, 12'hFA0, 4'b0);
        chk("lsr31", ALU_result, 32'h00000001);
        op(MOV, 32'h0, 32'h12345678, 1'b0, 12'h460, 4'b0);
        chk("ror8", ALU_result, 32'h78123456);
        op(MOV, 32'h0, 32'h12345678, 1'b0, 12'h060, 4'b0);
        chk("ror0", ALU_result, 32'h12345678);
        op(MOV, 32'h0, 32'h80000001, 1'b0, 12'h050, 4'b0);
        chk("asr0_b4", ALU_result, 32'h80000001);
        op(SUB, 32'h5, 32'h5, 1'b0, 12'h000, 4'b0);
        chk("sub_eq", ALU_result, 32'h0);
        chk("sub_eq_st", {28'b0, status}, 32'h6);
        op(SUB, 32'h1, 32'h2, 1'b0, 12'h000, 4'b0);
        chk("sub_borrow", ALU_result, 32'hFFFFFFFF);
        chk("sub_borrow_st", {28'b0, status}, 32'h8);
        op(SUB, 32'h80000000, 32'h1, 1'b0, 12'h000, 4'b0);
        chk("sub_ovf", ALU_result, 32'h7FFFFFFF);
        chk("sub_ovf_st", {28'b0, status}, 32'h3);
        op(ADC, 32'h1, 32'h0, 1'b1, 12'h001, 4'b0010);
        chk("adc", ALU_result, 32'h3);
        op(SBC, 32'h5, 32'h2, 1'b0, 12'h000, 4'b0000);
        chk("sbc_c0", ALU_result, 32'h2);
        chk("sbc_c0_st", {28'b0, status}, 32'h2);
        op(SBC, 32'h5, 32'h2, 1'b0, 12'h000, 4'b0010);
        chk("sbc_c1", ALU_result, 32'h3);
        op(MVN, 32'h0, 32'h0, 1'b1, 12'h000, 4'b0);
        chk("mvn", ALU_result, 32'hFFFFFFFF);
        chk("mvn_st", {28'b0, status}, 32'h8);
        op(AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 12'h000, 4'b0);
        chk("and", ALU_result, 32'hF000F000);
        op(ORR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 12'h000, 4'b0);
        chk("orr", ALU_result, 32'hFFF0FFF0);
        op(EOR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 12'h000, 4'b0);
        chk("eor", ALU_result, 32'h0FF00FF0);
        chk("eor_st", {28'b0, status}, 32'h0);
        op(4'b0000, 32'h5, 32'h7, 1'b0, 12'h000, 4'b1111);
        chk("undef0", ALU_result, 32'h0);
        chk("undef0_st", {28'b0, status}, 32'h0);
        op(4'b1111, 32'h5, 32'h7, 1'b1, 12'h0FF, 4'b1111);
        chk("undefF", ALU_result, 32'h0);

        MEM_R_EN = 1'b1;
        op(ADD, 32'h100, 32'h0, 1'b1, 12'hFFC, 4'b0);
        chk("ldr_addr", ALU_result, 32'h10FC);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b1;
        op(ADD, 32'h0, 32'hDEAD, 1'b0, 12'h123, 4'b0);
        chk("str_addr", ALU_result, 32'h123);
        MEM_W_EN = 1'b0;

        PC = 32'h20; Signed_imm_24 = 24'hFFFFFE;
        op(ADD, 32'h1, 32'h1, 1'b0, 12'h000, 4'b0);
        chk("br_neg", Br_addr, 32'h1E);
        PC = 32'hFFFFFFFF; Signed_imm_24 = 24'h000001;
        op(ADD, 32'h1, 32'h1, 1'b0, 12'h000, 4'b0);
        chk("br_wrap", Br_addr, 32'h0);
        chk("pre_pulse", ALU_result, 32'h2);

        PC = 32'h40; Signed_imm_24 = 24'h10;
        #2 rst = 1'b0;
        #1;
        chk("pulse_res", ALU_result, 32'h0);
        chk("pulse_br", Br_addr, 32'h0);
        @(posedge clk); #1;
        chk("pulse_hold", ALU_result, 32'h0);
        chk("pulse_hold_br", Br_addr, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("post_rel", ALU_result, 32'h0);
        @(posedge clk); #1;
        chk("first_edge", ALU_result, 32'h2);
        chk("first_edge_br", Br_addr, 32'h50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
